alu_seq_exec: RTL and testbench

- Execute-stage datapath that consumes the 3-bit ALU control code and the two operands, and produces a registered result.
- Bitwise, add, subtract and set-less-than complete in 1 cycle.
- MUL (ctrl 101) runs as an iterative shift-add multiplier over several cycles.
- While MUL runs, busy_o drives the hazard unit to stall IF/ID/EX.

---
 rtl/alu_seq_exec_if.sv | 24 ++
 rtl/alu_seq_exec.sv | 133 +++++++++++++
 tb/tb_alu_seq_exec.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_exec_if.sv
// Operand/result bundle between the issue logic and the execute-stage ALU.
// The master drives operands and control; the slave (ALU) returns busy/result.
interface alu_seq_exec_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  busy_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output busy_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith/SLT plus an iterative shift-add MUL.
// Define ALU_MUL_EARLY_TERM_EN to let MUL finish once the remaining multiplier is zero.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_seq_exec_if.slave bus
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             zero_reg, zero_next;
  logic             valid_reg, valid_next;

  logic [WIDTH-1:0] and_res, or_res, alu_res;
  logic [WIDTH-1:0] acc_step, mplier_shift;
  logic             mul_done;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_res[gi] = bus.data1_i[gi] & bus.data2_i[gi];
      assign or_res[gi]  = bus.data1_i[gi] | bus.data2_i[gi];
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      OP_AND:  alu_res = and_res;
      OP_OR:   alu_res = or_res;
      OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1_i) < $signed(bus.data2_i))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; the same update is used for the completion edge.
  always_comb begin
    acc_step     = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    mplier_shift = mplier_reg >> 1;
`ifdef ALU_MUL_EARLY_TERM_EN
    mul_done     = (cnt_reg == CNT_W'(WIDTH-1)) || (mplier_shift == '0);
`else
    mul_done     = (cnt_reg == CNT_W'(WIDTH-1));
`endif
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    zero_next   = zero_reg;
    valid_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            acc_next    = '0;
            mcand_next  = bus.data1_i;
            mplier_next = bus.data2_i;
            cnt_next    = '0;
            state_next  = MUL;
          end else begin
            data_next  = alu_res;
            zero_next  = (alu_res == '0);
            valid_next = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_shift;
        cnt_next    = cnt_reg + CNT_W'(1);
        if (mul_done) begin
          data_next  = acc_step;
          zero_next  = (acc_step == '0);
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      data_reg   <= '0;
      zero_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
      zero_reg   <= zero_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.busy_o  = (state_reg == MUL);
  assign bus.valid_o = valid_reg;
  assign bus.data_o  = data_reg;
  assign bus.zero_o  = zero_reg;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized + directed bench for alu_seq_exec against a cycle-count/arithmetic model.
// Define ALU_MUL_EARLY_TERM_EN here as well when the DUT is built with it.
module tb_alu_seq_exec;
  localparam int WIDTH = 32;
`ifdef ALU_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_exec #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles of MUL still to run, pending product, visible outputs.
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_zero  = 1'b0;
  bit          m_live  = 1'b0;

  function automatic logic [31:0] ref_result(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int mul_cycles(input logic [31:0] b);
    int n;
    if (!EARLY) return WIDTH;
    n = 0;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) n = i + 1;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_valid = 1'b0; m_data = '0; m_zero = 1'b0; m_live = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      m_valid = (m_left == 0);
      if (m_left == 0) begin
        m_data = m_pend;
        m_zero = (m_pend == 0);
      end
    end else begin
      m_valid = 1'b0;
      if (bus.valid_i) begin
        if (bus.ALUCtrl_i == 3'b101) begin
          m_left = mul_cycles(bus.data2_i);
          m_pend = ref_result(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
        end else begin
          m_valid = 1'b1;
          m_data  = ref_result(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
          m_zero  = (m_data == 0);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("cyc_busy",  {31'd0, bus.busy_o},  {31'd0, (m_left > 0)});
      check("cyc_valid", {31'd0, bus.valid_o}, {31'd0, m_valid});
      check("cyc_data",  bus.data_o, m_data);
      check("cyc_zero",  {31'd0, bus.zero_o},  {31'd0, m_zero});
      if (bus.valid_o && bus.busy_o) check("valid_and_busy", 32'd1, 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = v; bus.ALUCtrl_i = c; bus.data1_i = a; bus.data2_i = b;
  endtask

  // Issue one op, wait (bounded) for its result, check against literals.
  task automatic do_op(input string name, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_busy);
    int busy_cnt;
    bit got;
    busy_cnt = 0; got = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, c, a, b);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.valid_o) got = 1'b1;
      else begin
        if (bus.busy_o) busy_cnt++;
        @(posedge clk); #1;
      end
    end
    check({name, "_done"}, {31'd0, got}, 32'd1);
    if (got) begin
      check(name, bus.data_o, exp);
      check({name, "_z"}, {31'd0, bus.zero_o}, {31'd0, (exp == 0)});
    end
    if (exp_busy >= 0) check({name, "_busy"}, busy_cnt, exp_busy);
  endtask

  logic [2:0]  codes [8];
  logic [31:0] specials [6];

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int busy_cnt;
    bit got;
    codes = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b101, 3'b011, 3'b100};
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_00FF};
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, bus.busy_o},  32'd0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_data",  bus.data_o, 32'd0);
    check("rst_zero",  {31'd0, bus.zero_o},  32'd0);
    rst = 1'b0;

    do_op("add_wrap", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    do_op("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 0);
    do_op("slt_neg",  3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    do_op("slt_swap", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
    do_op("and",      3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    do_op("or",       3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
    do_op("unused3",  3'b011, 32'h1234, 32'h5678, 32'd0, 0);
    do_op("mul_ff",   3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32);
    do_op("mul_x0",   3'b101, 32'd7, 32'd0, 32'd0, EARLY ? 1 : 32);
    do_op("mul_xff",  3'b101, 32'd3, 32'h0000_00FF, 32'd765, EARLY ? 8 : 32);

    // MUL with the next instruction held on the inputs during busy.
    @(posedge clk); #1;
    drive(1'b1, 3'b101, 32'h0000_1234, 32'h0000_0100);
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd2, 32'd3);
    busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.valid_o) got = 1'b1;
      else begin
        if (bus.busy_o) busy_cnt++;
        @(posedge clk); #1;
      end
    end
    check("hold_mul", bus.data_o, 32'h0012_3400);
    check("hold_busy", busy_cnt, EARLY ? 9 : 32);
    @(posedge clk); #1;
    check("hold_next_valid", {31'd0, bus.valid_o}, 32'd1);
    check("hold_next_data", bus.data_o, 32'd5);
    bus.valid_i = 1'b0;

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    drive(1'b1, 3'b101, 32'd3, 32'd4);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_busy", {31'd0, bus.busy_o}, EARLY ? 32'd0 : 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",  {31'd0, bus.busy_o},  32'd0);
    check("abort_valid", {31'd0, bus.valid_o}, 32'd0);
    check("abort_data",  bus.data_o, 32'd0);
    do_op("post_rst_add", 3'b010, 32'd2, 32'd2, 32'd4, 0);

    // Back-to-back single-cycle ops.
    @(posedge clk); #1;
    drive(1'b1, 3'b010, 32'd10, 32'd20);
    @(posedge clk); #1;
    check("b2b_add", bus.data_o, 32'd30);
    check("b2b_add_busy", {31'd0, bus.busy_o}, 32'd0);
    drive(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
    @(posedge clk); #1;
    check("b2b_or_v", {31'd0, bus.valid_o}, 32'd1);
    check("b2b_or", bus.data_o, 32'h0000_00FF);
    drive(1'b1, 3'b110, 32'd100, 32'd1);
    @(posedge clk); #1;
    check("b2b_sub_v", {31'd0, bus.valid_o}, 32'd1);
    check("b2b_sub", bus.data_o, 32'd99);
    check("b2b_sub_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.valid_i = 1'b0;

    // Random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      drive($urandom_range(0, 1) == 1, codes[$urandom_range(0, 7)], pick_operand(), pick_operand());
    end
    rst = 1'b0;
    bus.valid_i = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
